// File: rtl/hamming_pkg.sv
// Shared constants and FSM state type for the Hamming encode scheduler.
// Holds data/code widths, the statistics counter width and the state enum.
package hamming_pkg;

    localparam int DATA_W = 7;
    localparam int CODE_W = 11;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENCODE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/hamming_enc.sv
// Purely combinational 7-to-11 Hamming encoder.
// Ports: i_word (7-bit data, x1 = bit 0), o_code (11-bit codeword, z1 = bit 0).
module hamming_enc
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] i_word,
    output logic [CODE_W-1:0] o_code
);

    logic [DATA_W-1:0] w_x;

    assign w_x = i_word;

    // Data occupies the non-power-of-two positions; parity sits at 1,2,4,8.
    assign o_code = {
        w_x[6],
        w_x[5],
        w_x[4],
        w_x[4] ^ w_x[5] ^ w_x[6],
        w_x[3],
        w_x[2],
        w_x[1],
        w_x[3] ^ w_x[2] ^ w_x[1],
        w_x[0],
        w_x[6] ^ w_x[5] ^ w_x[3] ^ w_x[2] ^ w_x[0],
        w_x[6] ^ w_x[4] ^ w_x[3] ^ w_x[1] ^ w_x[0]
    };

endmodule

// File: rtl/hamming_sched.sv
// Round-robin scheduler sharing one Hamming encoder among NUM_REQ requesters.
// Ports: clk, rst (async, active-high); req_valid/req_data/req_ready per
// requester; out_valid/out_ready/out_code/out_id codeword output; busy.
// Optional HAMMING_SCHED_STATS_EN adds grant_cnt (16-bit saturating
// per-requester grant counters).
module hamming_sched
    import hamming_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CODE_W-1:0]         out_code,
    output logic [ID_W-1:0]           out_id,
`ifdef HAMMING_SCHED_STATS_EN
    output logic [NUM_REQ*CNT_W-1:0]  grant_cnt,
`endif
    output logic                      busy
);

    state_t            r_state;
    state_t            w_next;
    logic [ID_W-1:0]   r_last;
    logic [ID_W-1:0]   r_id;
    logic [ID_W-1:0]   r_out_id;
    logic [DATA_W-1:0] r_word;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_code;
    logic [ID_W-1:0]   w_gnt_id;
    logic              w_found;
    logic              w_grant;
    logic [DATA_W-1:0] w_words [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_words[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Search from last_grant+1 upwards, wrapping past NUM_REQ-1 to 0.
    // The last candidate visited is last_grant itself.
    always_comb begin
        logic [ID_W:0]   v_sum;
        logic [ID_W-1:0] v_idx;
        w_found  = 1'b0;
        w_gnt_id = '0;
        v_sum    = '0;
        v_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_sum = {1'b0, r_last} + (ID_W+1)'(k);
            if (v_sum >= (ID_W+1)'(NUM_REQ)) begin
                v_sum = v_sum - (ID_W+1)'(NUM_REQ);
            end
            v_idx = v_sum[ID_W-1:0];
            if (!w_found && req_valid[v_idx]) begin
                w_found  = 1'b1;
                w_gnt_id = v_idx;
            end
        end
    end

    hamming_enc u_enc (
        .i_word (r_word),
        .o_code (w_code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        out_valid = 1'b0;
        busy      = 1'b1;
        w_grant   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_found) begin
                    w_grant             = 1'b1;
                    req_ready[w_gnt_id] = 1'b1;
                    w_next              = ST_ENCODE;
                end
            end
            ST_ENCODE: begin
                w_next = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        // Strobe must vanish the instant reset rises, not at the next edge.
        if (rst) begin
            req_ready = '0;
            w_grant   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last   <= ID_W'(NUM_REQ - 1);
            r_id     <= '0;
            r_word   <= '0;
            r_code   <= '0;
            r_out_id <= '0;
        end else begin
            if (w_grant) begin
                r_last <= w_gnt_id;
                r_id   <= w_gnt_id;
                r_word <= w_words[w_gnt_id];
            end
            if (r_state == ST_ENCODE) begin
                r_code   <= w_code;
                r_out_id <= r_id;
            end
        end
    end

    assign out_code = r_code;
    assign out_id   = r_out_id;

`ifdef HAMMING_SCHED_STATS_EN
    logic [CNT_W-1:0] r_cnt [NUM_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant && w_gnt_id == ID_W'(i) && r_cnt[i] != '1) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_hamming_sched.sv
// Self-checking bench for hamming_sched: directed steps plus random words
// compared against a position-based Hamming and round-robin reference model.
module tb_hamming_sched;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [27:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [10:0] out_code;
    logic [1:0]  out_id;
    logic        busy;
`ifdef HAMMING_SCHED_STATS_EN
    logic [63:0] grant_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int m_last   = N - 1;
    int m_cnt [N];

    always #5 clk = ~clk;

    hamming_sched #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_id    (out_id),
`ifdef HAMMING_SCHED_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Classic Hamming: data in non-power-of-two positions, parity at 2^b
    // covering every position whose index has bit b set.
    function automatic logic [10:0] ref_code(input logic [6:0] x);
        logic [10:0] z;
        logic        par;
        int          d;
        z = '0;
        d = 0;
        for (int p = 1; p <= 11; p++) begin
            if ((p & (p - 1)) != 0) begin
                z[p-1] = x[d];
                d++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            par = 1'b0;
            for (int p = 1; p <= 11; p++) begin
                if (((p >> b) & 1) == 1) par = par ^ z[p-1];
            end
            z[(1 << b) - 1] = par;
        end
        return z;
    endfunction

    function automatic int ref_pick(input logic [3:0] m);
        int idx;
        for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (m[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        m_last = N - 1;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // Caller has set a non-zero req_valid at posedge+1 while in IDLE.
    task automatic run_word(input int hold);
        int          id;
        logic [10:0] code;
        #1;
        id   = ref_pick(req_valid);
        code = ref_code(req_data[7*id +: 7]);
        out_ready = 1'b0;
        chk("grant_onehot", 32'(req_ready), 32'(1 << id));
        chk("idle_busy", 32'(busy), 0);
        m_last = id;
        m_cnt[id]++;
        @(posedge clk); #1;
        req_valid = 4'($urandom);
        req_data  = 28'($urandom);
        #1;
        chk("enc_req_ready", 32'(req_ready), 0);
        chk("enc_out_valid", 32'(out_valid), 0);
        chk("enc_busy", 32'(busy), 1);
        @(posedge clk); #1;
        chk("hold_out_valid", 32'(out_valid), 1);
        chk("hold_code", 32'(out_code), 32'(code));
        chk("hold_id", 32'(out_id), 32'(id));
        for (int h = 0; h < hold; h++) begin
            req_valid = 4'($urandom);
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_code", 32'(out_code), 32'(code));
            chk("bp_id", 32'(out_id), 32'(id));
            chk("bp_req_ready", 32'(req_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("back_idle_busy", 32'(busy), 0);
        chk("back_idle_valid", 32'(out_valid), 0);
    endtask

    initial begin
        logic [6:0] bnd [3];
        logic [10:0] bnd_exp [3];
        for (int i = 0; i < N; i++) m_cnt[i] = 0;

        // Reset values while rst is held and requests are pending.
        req_valid = 4'hF;
        #2;
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_code", 32'(out_code), 0);
        chk("reset_out_id", 32'(out_id), 0);
        chk("reset_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single word straight out of reset.
        req_valid = 4'b0001;
        req_data  = 28'h0000001;
        run_word(0);
        chk("single_code", 32'(out_code), 32'h007);
        chk("single_id", 32'(out_id), 0);

        // Idle with nothing requested.
        req_valid = '0;
        #1;
        chk("idle_no_req", 32'(req_ready), 0);
        @(posedge clk); #1;
        chk("idle_stays", 32'(busy), 0);

        // Encoding boundaries.
        bnd[0] = 7'h7F; bnd_exp[0] = 11'h7FF;
        bnd[1] = 7'h40; bnd_exp[1] = 11'h483;
        bnd[2] = 7'h00; bnd_exp[2] = 11'h000;
        for (int i = 0; i < 3; i++) begin
            req_valid = 4'b0001;
            req_data  = {21'h0, bnd[i]};
            run_word(0);
            chk("boundary_code", 32'(out_code), 32'(bnd_exp[i]));
        end

        // Fairness from a fresh reset: expect 0,1,2,3,0,1,2,3.
        do_reset();
        for (int w = 0; w < 8; w++) begin
            req_valid = 4'hF;
            req_data  = 28'($urandom);
            run_word(0);
            chk("fair_order", 32'(out_id), 32'(w % 4));
        end

        // Backpressure for 10 cycles.
        req_valid = 4'b0100;
        req_data  = 28'($urandom);
        run_word(10);

        // Random masks, data and hold lengths.
        for (int w = 0; w < 24; w++) begin
            req_valid = 4'($urandom_range(1, 15));
            req_data  = 28'($urandom);
            run_word(int'($urandom_range(0, 3)));
        end

        // Reset during ENCODE discards the word.
        req_valid = 4'b0001;
        req_data  = 28'($urandom);
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        chk("rst_enc_busy", 32'(busy), 0);
        chk("rst_enc_ready", 32'(req_ready), 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rst_enc_no_valid", 32'(out_valid), 0);
        end
        rst = 1'b0;
        m_last = N - 1;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        req_valid = 4'b0010;
        req_data  = 28'($urandom);
        run_word(0);
        chk("post_rst_id", 32'(out_id), 1);

        // Reset during HOLD drops out_valid at once.
        req_valid = 4'b1000;
        run_word(-1);
        req_valid = 4'b0100;
        #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("hold_before_rst", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("rst_hold_valid", 32'(out_valid), 0);
        chk("rst_hold_code", 32'(out_code), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        m_last = N - 1;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;

`ifdef HAMMING_SCHED_STATS_EN
        for (int g = 0; g < 3; g++) begin
            req_valid = 4'b0100;
            req_data  = 28'($urandom);
            run_word(0);
        end
        req_valid = '0;
        chk("stats_req2", 32'(grant_cnt[47:32]), 3);
        for (int i = 0; i < N; i++) begin
            chk("stats_model", 32'(grant_cnt[16*i +: 16]), 32'(m_cnt[i]));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hamming_sched.md
HAMMING_SCHED -- requirements
Module: hamming_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing the encoder (legal range 2..8).
REQ-002 Parameter ID_W, default 2, SHALL be the requester-index width (clog2(NUM_REQ)).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, SHALL be asynchronous and active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester word-available flag.
REQ-006 req_data  input  NUM_REQ*7  per-requester 7-bit data word; requester i occupies bits [7i+6:7i].
REQ-007 req_ready  output  NUM_REQ  one-hot accept strobe.
REQ-008 out_valid  output  1  codeword available.
REQ-009 out_ready  input  1  downstream accepts the codeword.
REQ-010 out_code  output  11  Hamming codeword, bit 1 is the LSB.
REQ-011 out_id  output  ID_W  index of the requester that produced out_code.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, ENCODE and HOLD.
REQ-014 In IDLE with any req_valid high, the block SHALL grant one requester round-robin, starting the search at last_grant+1 and wrapping at NUM_REQ-1 to 0.
REQ-015 On a grant, the block SHALL pulse req_ready[g] for exactly that cycle, capture req_data[g] and g, and move to ENCODE.
REQ-016 In IDLE with no req_valid, req_ready SHALL be all-zero and the state SHALL stay IDLE.
REQ-017 ENCODE SHALL last one cycle and SHALL register the encoder output into out_code and the captured index into out_id, then move to HOLD.
REQ-018 HOLD SHALL assert out_valid; out_code and out_id SHALL stay stable until out_ready is high, and on that cycle the state SHALL return to IDLE.
REQ-019 Latency SHALL be fixed: for a grant at cycle N, out_valid SHALL first be high at cycle N+2.
REQ-020 Maximum throughput SHALL be one word per 3 cycles.
REQ-021 req_ready SHALL be zero in ENCODE and HOLD, whatever req_valid does.
REQ-022 Encoding (x = captured word, z = out_code):
- z11=x7, z10=x6, z9=x5, z8=x5^x6^x7
- z7=x4, z6=x3, z5=x2, z4=x4^x3^x2
- z3=x1, z2=x7^x6^x4^x3^x1, z1=x7^x5^x4^x2^x1
REQ-023 A requester whose req_valid drops before it is granted SHALL be skipped without a pulse.
REQ-024 last_grant SHALL update only on a grant.

Reset
REQ-025 rst high SHALL immediately force: state IDLE, req_ready 0, out_valid 0, out_code 0, out_id 0, busy 0, last_grant NUM_REQ-1 (so requester 0 wins first).
REQ-026 Asserting rst in ENCODE or HOLD SHALL discard the in-flight word with no out_valid pulse.
REQ-027 The first grant SHALL be possible on the first clk edge after rst deasserts.

Configuration
REQ-028 With HAMMING_SCHED_STATS_EN defined:
- add output grant_cnt, NUM_REQ*16 bits, one 16-bit counter per requester
- counter i SHALL increment on each grant to i and saturate at 0xFFFF
- all counters SHALL reset to 0
REQ-029 Without HAMMING_SCHED_STATS_EN, the grant_cnt port and its counters SHALL not exist.

Structure
REQ-030 Package hamming_pkg SHALL hold: DATA_W=7, CODE_W=11, the FSM state enum, and the counter width 16.
REQ-031 Sub-module hamming_enc SHALL be a purely combinational 7-to-11 encoder implementing REQ-022, instantiated once.

Verification
REQ-032 Single word: req_valid=0001 with req_data[0]=7'h01 -> req_ready=0001 for 1 cycle; out_valid 2 cycles later with out_code=11'h007, out_id=0.
REQ-033 Encoding boundaries:
- x=7'h7F -> out_code=11'h7FF
- x=7'h40 -> out_code=11'h483
- x=7'h00 -> out_code=11'h000
REQ-034 Fairness: req_valid=1111 held for 8 words -> grant order 0,1,2,3,0,1,2,3.
REQ-035 Backpressure: out_ready=0 for 10 cycles in HOLD -> out_valid, out_code and out_id stable, req_ready stays 0; out_ready=1 -> IDLE next cycle.
REQ-036 Reset: rst asserted during ENCODE -> out_valid never rises; after release with req_valid=0010, requester 1 is granted.
REQ-037 Stats (macro on): 3 grants to requester 2 -> grant_cnt[47:32]=3, all other counters 0.
